// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and state encoding for the multicycle MIPS datapath
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;
endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: conditional two's-complement negate, used for operand magnitude and result sign
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    assign res = neg ? -val : val;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply (shift-add) and divide (restoring), one bit per cycle
module mult_div_unit #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mult_start,
    input  logic              div_start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              mult_done,
    output logic              div_done,
    output logic              div_zero,
    output logic              busy
);
    import cpu_pkg::*;

    md_state_e             state, state_nx;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W-1:0]   acc;
    logic [DATA_W-1:0]     mag_b;
    logic                  sign_a, sign_b, is_div, dz;
    logic [DATA_W-1:0]     abs_a, abs_b, quot_fix, rem_fix;
    logic [2*DATA_W-1:0]   prod_fix;
    logic [DATA_W:0]       add_sum, rem_sh;
    logic [DATA_W-1:0]     trial;
    logic                  last;

    md_sign_fix #(.W(DATA_W))   u_abs_a (.val(op_a), .neg(op_a[DATA_W-1]), .res(abs_a));
    md_sign_fix #(.W(DATA_W))   u_abs_b (.val(op_b), .neg(op_b[DATA_W-1]), .res(abs_b));
    md_sign_fix #(.W(2*DATA_W)) u_prod  (.val(acc), .neg(sign_a ^ sign_b), .res(prod_fix));
    md_sign_fix #(.W(DATA_W))   u_quot  (.val(acc[DATA_W-1:0]), .neg(sign_a ^ sign_b), .res(quot_fix));
    md_sign_fix #(.W(DATA_W))   u_rem   (.val(acc[2*DATA_W-1:DATA_W]), .neg(sign_a), .res(rem_fix));

    // Upper accumulator half plus multiplicand when the multiplier LSB is set; carry kept for the shift
    assign add_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mag_b} : '0);
    // Remainder after the left shift, one bit wider so the trial compare never wraps
    assign rem_sh  = acc[2*DATA_W-1:DATA_W-1];
    // Low bits suffice: a kept difference is always below the divisor
    assign trial   = rem_sh[DATA_W-1:0] - mag_b;
    assign last    = cnt == CNT_W'(1);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= MD_IDLE;
        else          state <= state_nx;
    end

    // Next-state selection; mult wins over div, divide-by-zero skips the iterations
    always_comb begin
        state_nx = state;
        busy     = state != MD_IDLE;
        case (state)
            MD_IDLE: state_nx = mult_start ? MD_MULT : div_start ? (|op_b ? MD_DIV : MD_DONE) : MD_IDLE;
            MD_MULT: state_nx = last ? MD_DONE : MD_MULT;
            MD_DIV:  state_nx = last ? MD_DONE : MD_DIV;
            default: state_nx = MD_IDLE;
        endcase
    end

    // Operand capture, per-bit iteration and sign-corrected result registration
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            acc       <= '0;
            mag_b     <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            is_div    <= 1'b0;
            dz        <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            mult_done <= 1'b0;
            div_done  <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            mult_done <= 1'b0;
            div_done  <= 1'b0;
            div_zero  <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (mult_start || div_start) begin
                        acc    <= {{DATA_W{1'b0}}, abs_a};
                        mag_b  <= abs_b;
                        sign_a <= op_a[DATA_W-1];
                        sign_b <= op_b[DATA_W-1];
                        is_div <= !mult_start;
                        dz     <= !mult_start && op_b == '0;
                        cnt    <= CNT_W'(DATA_W);
                    end
                end
                MD_MULT: begin
                    acc <= {add_sum, acc[DATA_W-1:1]};
                    cnt <= cnt - 1'b1;
                end
                MD_DIV: begin
                    acc <= (rem_sh >= {1'b0, mag_b}) ? {trial, acc[DATA_W-2:0], 1'b1}
                                                     : {acc[2*DATA_W-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                end
                default: begin
                    if (!is_div) begin
                        {hi, lo}  <= prod_fix;
                        mult_done <= 1'b1;
                    end else begin
                        if (!dz) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                        div_done <= 1'b1;
                        div_zero <= dz;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        mult_start, div_start;
    logic [31:0] op_a, op_b;
    logic [31:0] hi, lo;
    logic        mult_done, div_done, div_zero, busy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_hilo = '0;

    mult_div_unit dut (
        .clk(clk), .reset_n(reset_n), .mult_start(mult_start), .div_start(div_start),
        .op_a(op_a), .op_b(op_b), .hi(hi), .lo(lo), .mult_done(mult_done),
        .div_done(div_done), .div_zero(div_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] prev);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) return 64'(sa * sb);
        if (b == 0) return prev;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input logic ms, input logic ds, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcyc, output logic got_m, output logic got_d,
                          output logic got_z, output logic stuck);
        @(negedge clk);
        mult_start = ms; div_start = ds; op_a = a; op_b = b;
        @(posedge clk);
        @(negedge clk);
        mult_start = 1'b0; div_start = 1'b0; op_a = $urandom; op_b = $urandom;
        lat = -1; bcyc = int'(busy); got_m = 1'b0; got_d = 1'b0; got_z = 1'b0; stuck = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (mult_done || div_done) begin
                lat = n; got_m = mult_done; got_d = div_done; got_z = div_zero;
                break;
            end
            bcyc += int'(busy);
        end
        if (lat > 0) begin
            @(negedge clk);
            stuck = mult_done | div_done | busy;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; mult_start = 1'b0; div_start = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin miscompares++; $display("FAIL reset_hilo: got %h_%h want 0", hi, lo); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if ({mult_done, div_done, div_zero} !== 3'b000) begin miscompares++; $display("FAIL reset_done: got %b want 000", {mult_done, div_done, div_zero}); end
        reset_n = 1'b1;
        exp_hilo = '0;
    endtask

    task automatic test_mult_basic;
        int lat, bc; logic gm, gd, gz, st;
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, lat, bc, gm, gd, gz, st);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL mult_latency: got %0d want 33", lat); end
        vectors++; if (bc !== 33) begin miscompares++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
        vectors++; if ({gm, gd, gz} !== 3'b100) begin miscompares++; $display("FAIL mult_done_lines: got %b want 100", {gm, gd, gz}); end
        vectors++; if (st !== 1'b0) begin miscompares++; $display("FAIL mult_pulse_width: got %b want 0", st); end
        vectors++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin miscompares++; $display("FAIL mult_7x-3: got %h_%h want ffffffff_ffffffeb", hi, lo); end
        exp_hilo = 64'hFFFFFFFF_FFFFFFEB;
    endtask

    task automatic test_mult_edges;
        int lat, bc; logic gm, gd, gz, st;
        run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, lat, bc, gm, gd, gz, st);
        vectors++; if ({hi, lo} !== 64'h40000000_00000000) begin miscompares++; $display("FAIL mult_minxmin: got %h_%h want 40000000_00000000", hi, lo); end
        run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, gm, gd, gz, st);
        vectors++; if ({hi, lo} !== 64'h00000000_00000001) begin miscompares++; $display("FAIL mult_m1xm1: got %h_%h want 00000000_00000001", hi, lo); end
        exp_hilo = 64'h1;
    endtask

    task automatic test_div_basic;
        int lat, bc; logic gm, gd, gz, st;
        run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, lat, bc, gm, gd, gz, st);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL div_latency: got %0d want 33", lat); end
        vectors++; if ({gm, gd, gz} !== 3'b010) begin miscompares++; $display("FAIL div_done_lines: got %b want 010", {gm, gd, gz}); end
        vectors++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin miscompares++; $display("FAIL div_-7/2: got %h_%h want ffffffff_fffffffd", hi, lo); end
        run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc, gm, gd, gz, st);
        vectors++; if ({hi, lo} !== 64'h00000000_80000000) begin miscompares++; $display("FAIL div_min/-1: got %h_%h want 00000000_80000000", hi, lo); end
        exp_hilo = 64'h00000000_80000000;
    endtask

    task automatic test_div_zero;
        int lat, bc; logic gm, gd, gz, st;
        run_op(1'b0, 1'b1, 32'h451, 32'h20, lat, bc, gm, gd, gz, st);
        vectors++; if ({hi, lo} !== 64'h00000011_00000022) begin miscompares++; $display("FAIL div_setup: got %h_%h want 00000011_00000022", hi, lo); end
        run_op(1'b0, 1'b1, 32'd5, 32'd0, lat, bc, gm, gd, gz, st);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL divz_latency: got %0d want 1", lat); end
        vectors++; if ({gm, gd, gz} !== 3'b011) begin miscompares++; $display("FAIL divz_done_lines: got %b want 011", {gm, gd, gz}); end
        vectors++; if (bc !== 1) begin miscompares++; $display("FAIL divz_busy_cycles: got %0d want 1", bc); end
        vectors++; if ({hi, lo} !== 64'h00000011_00000022) begin miscompares++; $display("FAIL divz_hold: got %h_%h want 00000011_00000022", hi, lo); end
        exp_hilo = 64'h00000011_00000022;
    endtask

    task automatic test_back_to_back;
        int md_cnt, dd_cnt;
        md_cnt = 0; dd_cnt = 0;
        @(negedge clk);
        mult_start = 1'b1; div_start = 1'b1; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        mult_start = 1'b0; div_start = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk);
            @(negedge clk);
            md_cnt += int'(mult_done);
            dd_cnt += int'(div_done);
            div_start = (n == 10);
            if (n == 10) begin op_a = 32'd100; op_b = 32'd5; end
        end
        div_start = 1'b0;
        vectors++; if (md_cnt !== 1) begin miscompares++; $display("FAIL b2b_mult_done_count: got %0d want 1", md_cnt); end
        vectors++; if (dd_cnt !== 0) begin miscompares++; $display("FAIL b2b_div_done_count: got %0d want 0", dd_cnt); end
        vectors++; if ({hi, lo} !== 64'd12) begin miscompares++; $display("FAIL b2b_result: got %h_%h want 00000000_0000000c", hi, lo); end
        exp_hilo = 64'd12;
    endtask

    task automatic test_reset_mid_op;
        int dn, lat, bc; logic gm, gd, gz, st;
        dn = 0;
        @(negedge clk);
        mult_start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        mult_start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        vectors++; if ({hi, lo} !== 64'h0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_clear: got %h_%h busy %b want 0 busy 0", hi, lo, busy); end
        reset_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            dn += int'(mult_done | div_done);
        end
        vectors++; if (dn !== 0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_no_done: got %0d pulses busy %b want 0", dn, busy); end
        run_op(1'b1, 1'b0, 32'd9, 32'd9, lat, bc, gm, gd, gz, st);
        vectors++; if (lat !== 33 || {hi, lo} !== 64'd81) begin miscompares++; $display("FAIL midreset_rerun: got lat %0d %h_%h want 33 00000000_00000051", lat, hi, lo); end
        exp_hilo = 64'd81;
    endtask

    task automatic test_random;
        int lat, bc; logic gm, gd, gz, st;
        logic [31:0] a, b;
        logic        is_div;
        logic [63:0] want;
        for (int i = 0; i < 30; i++) begin
            is_div = i[0];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            if ($urandom_range(0, 5) == 0) b = $urandom_range(0, 3) == 0 ? 32'h0 : 32'hFFFFFFFF;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
            want = model(is_div, a, b, exp_hilo);
            run_op(!is_div, is_div, a, b, lat, bc, gm, gd, gz, st);
            vectors++;
            if ({hi, lo} !== want) begin
                miscompares++;
                $display("FAIL rand_%s a=%h b=%h: got %h_%h want %h", is_div ? "div" : "mult", a, b, hi, lo, want);
            end
            vectors++;
            if (lat !== ((is_div && b == 0) ? 1 : 33) || {gm, gd, gz} !== {!is_div, is_div, is_div && b == 0} || st !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_handshake a=%h b=%h: got lat %0d lines %b stuck %b", a, b, lat, {gm, gd, gz}, st);
            end
            exp_hilo = want;
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_mult_edges();
        test_div_basic();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide responder for the multicycle MIPS datapath; the other end of the control FSM's MultStart/DivStart -> mult_done_in/div_done_in handshake.
- Latches rs/rt operands on a start pulse and iterates one bit per cycle, shift-add for multiply and restoring division for divide.
- Presents a 64-bit result as hi/lo and pulses the matching done line.
- The external HI/LO registers capture hi/lo when the control unit asserts HIWrite/LOWrite.

Parameters:
- DATA_W, 32, operand width; only 32 is supported by the datapath.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- mult_start  in  1  one-cycle start for MULT; driven from MultStart.
- div_start  in  1  one-cycle start for DIV; driven from DivStart.
- op_a  in  DATA_W  rs value, two's complement; the dividend for DIV.
- op_b  in  DATA_W  rt value, two's complement; the divisor for DIV.
- hi  out  DATA_W  product[63:32] for MULT; remainder for DIV.
- lo  out  DATA_W  product[31:0] for MULT; quotient for DIV.
- mult_done  out  1  one-cycle pulse when MULT completes; drives mult_done_in.
- div_done  out  1  one-cycle pulse when DIV completes; drives div_done_in.
- div_zero  out  1  set together with div_done when op_b==0.
- busy  out  1  high from the start-sampling edge until the done pulse.

Behaviour:
- Reset (reset_n=0, any time, including mid-operation):
  - State goes to IDLE; counter and internal registers clear.
  - hi, lo, mult_done, div_done, div_zero and busy are all 0.
  - No done pulse is generated for an aborted operation.
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - mult_start=1: latch |op_a|, |op_b| and sign bits; load counter with DATA_W; go to MULT.
  - div_start=1 with op_b!=0: same latching; go to DIV.
  - div_start=1 with op_b==0: go directly to DONE with div_zero pending. hi and lo are left unchanged.
  - Both starts high in the same cycle: mult wins; div_start is ignored.
- MULT: each cycle, if multiplier LSB is 1, add multiplicand into upper accumulator half; shift the 64-bit accumulator right by 1 with carry in. Decrement counter; at count 1 go to DONE.
- DIV: each cycle, shift the {rem, quot} pair left by 1 and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB. Decrement counter; at count 1 go to DONE.
- DONE (one cycle):
  - Apply sign correction. Product is negated when sign_a^sign_b. Quotient is negated when sign_a^sign_b. Remainder takes the sign of the dividend.
  - Register hi/lo and pulse the matching done line and div_zero for that cycle; busy drops. Return to IDLE.
- Latency:
  - MULT and DIV: done is high in the cycle following exactly 33 rising edges after the edge that sampled start. That is 32 iteration edges plus 1 DONE edge.
  - Divide-by-zero: done is high after 1 edge.
- Starts seen while busy=1 are ignored; the operation in flight is not disturbed.
- hi/lo hold their last result until the next completion. Operands are sampled only at start, so op_a/op_b may change afterwards.
- Edge cases:
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out of the magnitude arithmetic and needs no special case.
  - Magnitude of 0x80000000 is computed in DATA_W+1 bits or as unsigned 0x80000000. No overflow trap is raised.
- div_done and mult_done are never high in the same cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - the MD state encoding (IDLE=0, MULT=1, DIV=2, DONE=3);
  - DATA_W;
  - F_MULT=6'b011000 and F_DIV=6'b011010, so the control unit and the bench agree.
- One natural sub-module, md_sign_fix: combinational magnitude/negate helper, instantiated for operand abs and result correction. The rest is a single FSM.

Test Plan:
- MULT op_a=7, op_b=0xFFFFFFFD (-3) -> after 33 edges mult_done=1 for 1 cycle; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; then 0xFFFFFFFF x 0xFFFFFFFF -> hi=0, lo=1.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> div_done at 33 edges; lo=0xFFFFFFFD, hi=0xFFFFFFFF; then 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5/0 after a prior result hi=0x11, lo=0x22 -> div_done and div_zero high on the next cycle; hi=0x11, lo=0x22 unchanged; busy 1 cycle.
- mult_start and div_start together with 3x4, then div_start pulsed at cycle 10 while busy -> only mult_done fires, lo=12, hi=0; no div_done within 40 cycles.
- Start MULT 9x9, drop reset_n at cycle 10 for 1 cycle, then release -> hi=lo=0, busy=0, and no done pulse for 40 cycles. A new MULT 9x9 then gives lo=81 at 33 edges.
